// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared types and constants for the stopwatch display path.
//            It holds the seven-segment glyph table (active-low, {g,f,e,d,c,b,a}),
//            the all-off segment pattern and the digit index/BCD types.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the glyph for code n. Codes 10..15 are not valid BCD.
  // They are shown as a dash (only g lit) so that a corrupted digit is visible.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F,  // 15..10 : dash
    7'h10,                                     // 9
    7'h00,                                     // 8
    7'h78,                                     // 7
    7'h02,                                     // 6
    7'h12,                                     // 5
    7'h19,                                     // 4
    7'h30,                                     // 3
    7'h24,                                     // 2
    7'h79,                                     // 1
    7'h40                                      // 0
  };

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg7
// Purpose  : Combinational BCD to seven-segment decoder. The output is active-low.
//            The pattern comes from the shared glyph table.
// Ports    : bcd_i  [3:0]  digit code
//            seg_o  [6:0]  segments {g,f,e,d,c,b,a}, active-low
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_GLYPH[bcd_i];

endmodule
`default_nettype wire

// File: rtl/stopwatch_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_display_scan
// Purpose  : Drives a 4-digit multiplexed common-anode seven-segment display.
//            The digits come from the stopwatch digit registers.
//            All four digits are captured once per frame, so a frame never tears.
//            The display shows one digit per slot.
//            Each slot begins with a short anti-ghost blank window.
//            The optional pause blink is enabled when DISP_BLINK_EN is defined.
// Ports    : clk          system clock
//            reset        synchronous active-high reset
//            digits_in    [15:0] {M1,M0,S1,S0} BCD
//            blink        blink request (used only with DISP_BLINK_EN)
//            seg          [6:0] segments {g,f,e,d,c,b,a}, active-low
//            dp           decimal point, active-low
//            an           [3:0] anode enables, active-low, an[i] = digit i
//            frame_start  one-cycle pulse when a new snapshot is taken
// Config   : DISP_BLINK_EN enables the paused-display blink.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_display_scan
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic        blink,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic             fs_q, fs_d;

  logic             tick;
  logic             frame_wrap;
  logic             blink_dark;
  logic             dark;
  bcd_t             cur_digit;
  logic [6:0]       cur_glyph;

  assign tick       = (div_cnt_q == DIV_LAST);
  assign frame_wrap = tick && (idx_q == 2'd3);
  assign cur_digit  = snap_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (cur_glyph)
  );

`ifdef DISP_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  // Blink timing restarts whenever blink drops.
  // A new pause therefore always begins with a lit half-period.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!blink) begin
      frame_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_dark = blink && blink_phase_q;
`else
  localparam int BLINK_FRAMES_unused = BLINK_FRAMES;
  logic blink_unused;
  assign blink_unused = blink;
  assign blink_dark   = 1'b0;
`endif

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    snap_d    = frame_wrap ? digits_in : snap_q;
    fs_d      = frame_wrap;

    // Outputs are computed from the current slot state and registered.
    // The pins therefore lag the internal state by exactly one cycle.
    dark  = (div_cnt_q < BLANK_END) || blink_dark;
    an_d  = dark ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = dark ? SEG_BLANK : cur_glyph;
    // The point after digit 2 separates minutes from seconds.
    dp_d  = !((idx_q == 2'd2) && !dark);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      an_q      <= 4'hF;
      fs_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      fs_q      <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_display_scan
// Purpose  : Self-checking bench for stopwatch_display_scan.
//            It uses REFRESH_DIV=8, BLANK_CYC=2 and BLINK_FRAMES=2.
//            A time-indexed display model is checked against the DUT every cycle.
//            Directed literal checks pin the model itself.
// Config   : honours DISP_BLINK_EN when it is defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display_scan;

  localparam int R  = 8;
  localparam int B  = 2;
  localparam int BF = 2;
`ifdef DISP_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = 16'h1234;
  logic        blink = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int failures = 0;

  stopwatch_display_scan #(
    .REFRESH_DIV  (R),
    .BLANK_CYC    (B),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_in   (digits_in),
    .blink       (blink),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The glyph is built from the list of lit segments, where a is bit 0 and g is bit 6.
  function automatic logic [6:0] model_glyph(input int d);
    string lit;
    logic [6:0] s;
    s = 7'h7F;
    case (d)
      0: lit = "abcdef";
      1: lit = "bc";
      2: lit = "abdeg";
      3: lit = "abcdg";
      4: lit = "bcfg";
      5: lit = "acdfg";
      6: lit = "acdefg";
      7: lit = "abc";
      8: lit = "abcdefg";
      9: lit = "abcdfg";
      default: lit = "g";
    endcase
    for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
    return s;
  endfunction

  // Model: the display state is a function of t, the number of cycles since reset.
  //   slot = t / R
  //   digit = slot % 4
  //   position in slot = t % R
  // At the negedge, the outputs show the state that held before the last posedge.
  // The inputs are also sampled at the negedge; they are stable around the posedge.
  int          m_t = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_snap;
  int          m_frames;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fs;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_t = 0; m_snap = 16'h0; m_frames = 0; m_valid = 1'b1;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fs = 1'b0;
      end else if (m_valid) begin
        int slot, pos, d;
        bit dk;
        slot = m_t / R;
        pos  = m_t % R;
        d    = slot % 4;
        dk   = (pos < B) || (BLINK_BUILD && blink && (((m_frames / BF) % 2) == 1));
        e_an  = dk ? 4'hF : 4'hF & ~(4'h1 << d);
        e_seg = dk ? 7'h7F : model_glyph(int'((m_snap >> (4 * d)) & 16'hF));
        e_dp  = !(d == 2 && !dk);
        e_fs  = (pos == R - 1) && (d == 3);
        if (e_fs) m_snap = digits_in;
        if (!blink) m_frames = 0;
        else if (e_fs) m_frames++;
        m_t++;
      end
      if (m_valid) begin
        chk($sformatf("model_an t=%0d", m_t), {28'h0, an}, {28'h0, e_an});
        chk($sformatf("model_seg t=%0d", m_t), {25'h0, seg}, {25'h0, e_seg});
        chk($sformatf("model_dp t=%0d", m_t), {31'h0, dp}, {31'h0, e_dp});
        chk($sformatf("model_fs t=%0d", m_t), {31'h0, frame_start}, {31'h0, e_fs});
      end
    end
  end

  int e = 0;  // posedges since the last reset release

  task automatic step_to(input int k);
    while (e < k) begin
      @(negedge clk);
      e++;
    end
    #2;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_an", {28'h0, an}, 32'hF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_dp", {31'h0, dp}, 32'h1);
    chk("rst_fs", {31'h0, frame_start}, 32'h0);
    reset = 1'b0; e = 0;

    // First frame shows snapshot 0. The next frame shows 1234.
    step_to(1);   chk("f1_blank_an", {28'h0, an}, 32'hF);
    step_to(3);   chk("f1_idx0_an", {28'h0, an}, 32'hE);
                  chk("f1_idx0_seg", {25'h0, seg}, 32'h40);
    step_to(17);  chk("f1_idx2_blank_dp", {31'h0, dp}, 32'h1);
    step_to(19);  chk("f1_idx2_dp", {31'h0, dp}, 32'h0);
                  chk("f1_idx2_an", {28'h0, an}, 32'hB);
    step_to(27);  chk("f1_idx3_an", {28'h0, an}, 32'h7);
                  chk("f1_idx3_seg", {25'h0, seg}, 32'h40);
    step_to(32);  chk("fs_pulse", {31'h0, frame_start}, 32'h1);
    step_to(33);  chk("fs_clear", {31'h0, frame_start}, 32'h0);
    step_to(35);  chk("f2_idx0_seg", {25'h0, seg}, 32'h19);
                  chk("f2_idx0_an", {28'h0, an}, 32'hE);
    step_to(59);  chk("f2_idx3_seg", {25'h0, seg}, 32'h79);
                  chk("f2_idx3_an", {28'h0, an}, 32'h7);

    // Tearing: the new value arrives during idx1 of a frame that shows zeros.
    step_to(64);  digits_in = 16'h0000;
    step_to(105); digits_in = 16'h5959;
    step_to(115); chk("tear_idx2_seg", {25'h0, seg}, 32'h40);
    step_to(123); chk("tear_idx3_seg", {25'h0, seg}, 32'h40);
    step_to(131); chk("new_idx0_seg", {25'h0, seg}, 32'h10);
    step_to(139); chk("new_idx1_seg", {25'h0, seg}, 32'h12);
    step_to(147); chk("new_idx2_seg", {25'h0, seg}, 32'h10);
    step_to(155); chk("new_idx3_seg", {25'h0, seg}, 32'h12);

    // Invalid code
    digits_in = 16'h00A0;
    step_to(163); chk("inv_idx0_seg", {25'h0, seg}, 32'h40);
    step_to(171); chk("inv_idx1_seg", {25'h0, seg}, 32'h3F);
                  chk("inv_idx1_an", {28'h0, an}, 32'hD);
    step_to(179); chk("inv_idx2_seg", {25'h0, seg}, 32'h40);

    // Reset mid-slot at idx2, div_cnt=5
    step_to(213); reset = 1'b1;
    step_to(214); chk("midrst_an", {28'h0, an}, 32'hF);
                  chk("midrst_seg", {25'h0, seg}, 32'h7F);
    reset = 1'b0; e = 0;
    step_to(1);   chk("restart_blank1", {28'h0, an}, 32'hF);
    step_to(2);   chk("restart_blank2", {28'h0, an}, 32'hF);
    step_to(3);   chk("restart_idx0_an", {28'h0, an}, 32'hE);
                  chk("restart_idx0_seg", {25'h0, seg}, 32'h40);

    // Blink: 2 frames lit, then 2 frames dark. Without DISP_BLINK_EN, blink is ignored.
    blink = 1'b1;
    step_to(67);  chk("blink_dark_an", {28'h0, an}, BLINK_BUILD ? 32'hF : 32'hE);
    step_to(131); chk("blink_lit_an", {28'h0, an}, 32'hE);
    step_to(199); chk("blink_dark2_an", {28'h0, an}, BLINK_BUILD ? 32'hF : 32'hE);
    step_to(200); blink = 1'b0;
    step_to(203); chk("blink_resume_an", {28'h0, an}, 32'hD);
    step_to(240);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_display_scan.md
Name: stopwatch_display_scan

Overview:
- Consumer side of the stopwatch digit chain: reads the four digit registers (S0, S1, M0, M1) and drives a 4-digit multiplexed common-anode seven-segment display.
- Time-multiplexes one digit per slot, snapshots all digits once per frame (no tearing), inserts anti-ghost blanking, optional pause blink.
- Sits between the digit blocks and the FPGA pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (1 kHz slot at 50 MHz); must be > BLANK_CYC + 1.
- BLANK_CYC, 16, cycles at start of each slot with all anodes off.
- BLINK_FRAMES, 125, frames per blink half-period (used only with DISP_BLINK_EN).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- digits_in  input  16  {M1,M0,S1,S0}, 4-bit BCD each, S0 in [3:0].
- blink  input  1  request blink (stopwatch paused); ignored without DISP_BLINK_EN.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  anode enables, active-low, an[i] selects digit i (0 = S0).
- frame_start  output  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (clk edge with reset=1): div_cnt=0, idx=0, snapshot=0, seg=7'h7F, dp=1, an=4'hF, frame_start=0, blink counters 0.
- div_cnt counts 0..REFRESH_DIV-1 and wraps; tick = (div_cnt == REFRESH_DIV-1).
- On tick: idx <= idx+1 mod 4 (2-bit wrap 3->0).
- On tick with idx==3: snapshot <= digits_in; frame_start <= 1 next cycle only. digits_in is never used unsnapshotted. After reset the display shows snapshot 0 until the first frame boundary.
- All outputs are registered; they reflect the current (idx, div_cnt, snapshot) one cycle later.
- Blanking: while div_cnt < BLANK_CYC, the registered an=4'hF and seg=7'h7F; otherwise an = ~(1<<idx) and seg = decode(snapshot digit idx).
- Decode: 0-9 use the standard seven-segment glyphs (0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, active-low). Codes 10-15 show a dash (only g lit, 7'h3F).
- dp is 0 (lit) only when idx==2 and the slot is not blanked; it separates minutes from seconds. Otherwise dp=1.
- Reset asserted mid-slot: all state returns to the reset values on that edge. Scanning restarts at idx=0 with a fresh blank window.
- digits_in changing mid-frame: no visible effect until the next 3->0 boundary.

Optional Feature:
- Macro DISP_BLINK_EN.
- Defined:
  - A frame counter increments on each frame_start and wraps at BLINK_FRAMES-1, toggling blink_phase.
  - While blink=1 and blink_phase=1: an=4'hF, seg=7'h7F, dp=1, and scanning continues.
  - When blink deasserts: the display resumes at the next slot; blink_phase is cleared.
  - Reset clears the frame counter and blink_phase.
- Not defined: the blink input is unused, no blink counter exists, and the display is never blanked beyond the BLANK_CYC window.

Decomposition:
- stopwatch_pkg holds:
  - SEG_GLYPH constant array (16 entries, 7-bit, active-low, including the dash).
  - SEG_BLANK = 7'h7F.
  - typedef digit_idx_t (logic [1:0]).
  - typedef bcd_t (logic [3:0]).
- Sub-module bcd_to_seg7: purely combinational, bcd_t in, 7-bit active-low out, table from the package.
- Counters, snapshot, blanking and blink logic live in the top block.

Test Plan (REFRESH_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2):
- Reset, then digits_in=16'h1234 held:
  - Frame 1 shows zeros (an cycles E,D,B,7; seg=7'h40).
  - After the first frame_start, slot idx0 shows seg=7'h19 ("4") with an=4'hE.
  - idx3 shows seg=7'h79 ("1") with an=4'h7.
- Blanking: in every slot, the first 2 output cycles have an=4'hF; the remaining 6 cycles have exactly one anode low. dp is low only in idx2 unblanked cycles.
- Tearing: change digits_in from 16'h0000 to 16'h5959 during idx1 of a frame -> that frame still shows 0 at idx2 and idx3. The next frame shows 9,5,9,5 (seg 7'h10 / 7'h12).
- Invalid code: digits_in=16'h00A0 -> idx1 shows seg=7'h3F, all other digits show 7'h40.
- Reset mid-slot: assert reset at idx2, div_cnt=5 -> the next cycle has an=4'hF, seg=7'h7F; on release, scanning restarts at idx0 with a 2-cycle blank.
- DISP_BLINK_EN with blink=1 -> the display alternates 2 frames lit / 2 frames dark (an=4'hF throughout the dark frames). Deasserting blink restores normal scanning within 1 slot.
